// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-ROM arbiter.
//   arb_state_t : arbiter FSM states (round-robin arbitration / streamer burst)
//   owner_t     : which requester a priority or grant refers to
//   addr_in_range : word-address range check against a ROM depth
package dmem_arb_pkg;

    localparam int DMEM_DEPTH = 8100;
    localparam int DMEM_AW    = 32;
    localparam int DMEM_DW    = 32;

    typedef enum logic {
        ARB     = 1'b0,
        S_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_S = 1'b1
    } owner_t;

    function automatic logic addr_in_range(input logic [DMEM_AW-1:0] addr,
                                           input int unsigned        depth);
        return addr < DMEM_AW'(depth);
    endfunction

endpackage

// File: rtl/dmem_rom_arbiter_if.sv
// Bus bundle between the two requesters (CPU "c", streamer "s"), the arbiter
// and the combinational-read ROM.
// Handshake: a requester raises *_req with *_addr and holds both stable until
// it sees *_gnt high in the same cycle; the transfer happens in that cycle.
// *_rvalid pulses for one cycle exactly one cycle after the grant, with
// *_rdata/*_err valid then and held until that port's next rvalid.
//   master : requester side (drives req/addr/lock, samples the rest);
//            also provides the ROM (drives rom_rd from rom_addr)
//   slave  : arbiter side
interface dmem_rom_arbiter_if;
    import dmem_arb_pkg::*;

    logic               c_req;
    logic [DMEM_AW-1:0] c_addr;
    logic               c_gnt;
    logic               c_rvalid;
    logic [DMEM_DW-1:0] c_rdata;
    logic               c_err;

    logic               s_req;
    logic               s_lock;
    logic [DMEM_AW-1:0] s_addr;
    logic               s_gnt;
    logic               s_rvalid;
    logic [DMEM_DW-1:0] s_rdata;
    logic               s_err;

    logic [DMEM_AW-1:0] rom_addr;
    logic [DMEM_DW-1:0] rom_rd;

    modport master (
        output c_req, c_addr, s_req, s_lock, s_addr, rom_rd,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        input  s_gnt, s_rvalid, s_rdata, s_err, rom_addr
    );

    modport slave (
        input  c_req, c_addr, s_req, s_lock, s_addr, rom_rd,
        output c_gnt, c_rvalid, c_rdata, c_err,
        output s_gnt, s_rvalid, s_rdata, s_err, rom_addr
    );

endinterface

// File: rtl/dmem_rd_port.sv
// Per-requester read-return register.
//   clk, rst   : clock, synchronous active-high reset
//   gnt        : this port was granted the ROM this cycle
//   in_range   : the granted address was inside the ROM
//   rom_rd     : combinational ROM data for the granted address
//   rvalid     : one-cycle pulse the cycle after a grant
//   rdata, err : loaded on each grant, held otherwise
module dmem_rd_port
    import dmem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               gnt,
    input  logic               in_range,
    input  logic [DMEM_DW-1:0] rom_rd,
    output logic               rvalid,
    output logic [DMEM_DW-1:0] rdata,
    output logic               err
);

    logic               rvalid_d, rvalid_q;
    logic [DMEM_DW-1:0] rdata_d,  rdata_q;
    logic               err_d,    err_q;

    always_comb begin
        rvalid_d = gnt;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (gnt) begin
            // Out-of-range reads return zero rather than whatever ROM[0] holds.
            rdata_d = in_range ? rom_rd : '0;
            err_d   = ~in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: rtl/dmem_rom_arbiter.sv
// Two-requester arbiter for the single-port image data ROM.
// Round-robin between CPU (c) and streamer (s); the streamer may hold the ROM
// for up to MAX_BURST consecutive grants by asserting s_lock.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : requester/ROM bundle (slave side)
//   dbg_state     : current FSM state
//   dbg_prio      : side favoured on the next contested ARB cycle
//   dbg_burst_cnt : grants taken so far in the current streamer burst
module dmem_rom_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int MAX_BURST = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    dmem_rom_arbiter_if.slave                  bus,
    output arb_state_t                         dbg_state,
    output owner_t                             dbg_prio,
    output logic [$clog2(MAX_BURST+1)-1:0]     dbg_burst_cnt
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t         state_d, state_q;
    owner_t             prio_d,  prio_q;
    logic [CW-1:0]      cnt_d,   cnt_q;
    logic [CW-1:0]      cnt_inc;
    logic               c_gnt, s_gnt;
    logic [DMEM_AW-1:0] gnt_addr;
    logic               in_range;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        c_gnt   = 1'b0;
        s_gnt   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    if (bus.c_req && (!bus.s_req || prio_q == OWN_C)) begin
                        c_gnt  = 1'b1;
                        prio_d = OWN_S;
                    end else if (bus.s_req) begin
                        s_gnt  = 1'b1;
                        prio_d = OWN_C;
                        // This grant is the first of the burst.
                        if (bus.s_lock && (MAX_BURST > 1)) begin
                            state_d = S_BURST;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                S_BURST: begin
                    if (bus.s_req) begin
                        s_gnt = 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(MAX_BURST) || !bus.s_lock) begin
                            state_d = ARB;
                            prio_d  = OWN_C;
                            cnt_d   = '0;
                        end
                    end else begin
                        // Streamer idle: release the ROM and let the CPU in
                        // without losing a cycle.
                        state_d = ARB;
                        prio_d  = OWN_C;
                        cnt_d   = '0;
                        if (bus.c_req) begin
                            c_gnt  = 1'b1;
                            prio_d = OWN_S;
                        end
                    end
                end
                default: begin
                    state_d = ARB;
                    prio_d  = OWN_C;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            prio_q  <= OWN_C;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_addr     = c_gnt ? bus.c_addr : bus.s_addr;
    assign in_range     = addr_in_range(gnt_addr, DEPTH);
    assign bus.rom_addr = ((c_gnt || s_gnt) && in_range) ? gnt_addr : '0;
    assign bus.c_gnt    = c_gnt;
    assign bus.s_gnt    = s_gnt;

    dmem_rd_port u_c_port (
        .clk      (clk),
        .rst      (rst),
        .gnt      (c_gnt),
        .in_range (in_range),
        .rom_rd   (bus.rom_rd),
        .rvalid   (bus.c_rvalid),
        .rdata    (bus.c_rdata),
        .err      (bus.c_err)
    );

    dmem_rd_port u_s_port (
        .clk      (clk),
        .rst      (rst),
        .gnt      (s_gnt),
        .in_range (in_range),
        .rom_rd   (bus.rom_rd),
        .rvalid   (bus.s_rvalid),
        .rdata    (bus.s_rdata),
        .err      (bus.s_err)
    );

    assign dbg_state     = state_q;
    assign dbg_prio      = prio_q;
    assign dbg_burst_cnt = cnt_q;

endmodule

// File: doc/dmem_rom_arbiter.md
Name: dmem_rom_arbiter

Overview:
- Shares the single-port, combinational-read image data ROM between two requesters.
  - Requester C: the pipeline memory stage.
  - Requester S: the image streamer, which supports bounded lock bursts.
- Grants at most one access per cycle, round-robin by default.
- Registers the ROM word, so read data returns one cycle after grant. Out-of-range addresses are flagged.
- Sits between the processor/streamer and the ROM; the ROM's read port is driven only by this block.

Parameters:
DEPTH, 8100, number of 32-bit ROM words; valid word addresses 0..DEPTH-1
MAX_BURST, 16, max consecutive grants S may hold under s_lock (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
c_req  in  1  CPU read request; held with c_addr stable until c_gnt
c_addr  in  32  CPU word address
c_gnt  out  1  combinational grant to CPU this cycle
c_rvalid  out  1  CPU read data valid (one cycle after c_gnt)
c_rdata  out  32  CPU read data, held until next c_rvalid
c_err  out  1  valid with c_rvalid: address was >= DEPTH
s_req  in  1  streamer read request; held with s_addr stable until s_gnt
s_lock  in  1  streamer requests burst ownership
s_addr  in  32  streamer word address
s_gnt  out  1  combinational grant to streamer this cycle
s_rvalid  out  1  streamer read data valid (one cycle after s_gnt)
s_rdata  out  32  streamer read data, held until next s_rvalid
s_err  out  1  valid with s_rvalid: address was >= DEPTH
rom_addr  out  32  address to ROM
rom_rd  in  32  combinational ROM read data

Behaviour:
- Reset (rst=1 at clock edge):
  - state=ARB, prio=C, burst_cnt=0.
  - c_rvalid, s_rvalid, c_err, s_err = 0; c_rdata, s_rdata = 0.
  - During rst, c_gnt, s_gnt = 0 and rom_addr = 0.
- Grants are combinational from state, prio and the req inputs; c_gnt and s_gnt are never both 1.
- rom_addr:
  - Equals the granted address when that address is < DEPTH.
  - Is 0 when the granted address is out of range, or when there is no grant.
- Data edge: at the clock edge ending grant cycle N, the granted port's rdata is loaded with rom_rd (or 0 if out of range). Its err is set to the range result and its rvalid=1 during N+1.
  - rvalid is a 1-cycle pulse per grant.
  - rdata/err hold until that port's next grant.
- Back-to-back: a requester may present a new request in N+1. Throughput is one read per cycle total.
- FSM states:
  - ARB:
    - Only one of c_req/s_req set: grant it.
    - Both set: grant the side prio favours.
    - After a C grant, prio=S. After an S grant, prio=C.
    - If S is granted and s_lock=1 and MAX_BURST>1: go to S_BURST with burst_cnt=1. Otherwise stay in ARB.
  - S_BURST:
    - s_req=1: grant S regardless of c_req; burst_cnt++. Return to ARB with prio=C when burst_cnt reaches MAX_BURST or s_lock=0 in a granted cycle.
    - s_req=0: no grant to S. Return to ARB with prio=C; C may be granted in this same cycle if c_req=1.
- Boundaries:
  - Address >= DEPTH (including upper bits set): grant normally, rdata=0, err=1. No effect on FSM or prio.
  - s_lock without s_req: ignored.
  - Reset mid-burst: the burst is aborted and the pending rvalid is suppressed (0 after reset).
  - Requests withdrawn before grant: permitted; nothing is issued.
- CPU worst-case wait: MAX_BURST cycles plus 1.

Decomposition:
- Package dmem_arb_pkg:
  - typedef arb_state_t {ARB, S_BURST}.
  - typedef owner_t {OWN_C, OWN_S}.
  - Constants DMEM_DEPTH=8100 and DMEM_AW=32.
- Sub-module dmem_rd_port:
  - Per-requester output register: rvalid pulse, rdata/err hold.
  - Instantiated twice.

Test Plan:
1. Reset, then c_req=1 with c_addr=5 (ROM[5]=0x0000_00AB): c_gnt=1 in cycle 0; c_rvalid=1 with c_rdata=0x000000AB, c_err=0 in cycle 1; s_gnt=0 throughout.
2. c_req=s_req=1 continuously, s_lock=0, addresses 10/20: grants alternate C,S,C,S starting with C; each rvalid follows its grant by exactly 1 cycle; c_rdata=ROM[10], s_rdata=ROM[20].
3. MAX_BURST=4, s_req=s_lock=1 and c_req=1 from the same cycle: C is granted first, then S for 4 consecutive cycles, then C, then S again; c_gnt never exceeds a 5-cycle gap.
4. c_addr=8100, then c_addr=0xFFFF_FFFF: c_gnt=1, rom_addr=0; next cycle c_rvalid=1, c_err=1, c_rdata=0.
5. rst=1 in the 2nd cycle of an S burst while s_gnt=1: the next cycle has s_rvalid=0, state=ARB and prio=C; with both requesting, C is granted first.
6. s_lock=1, s_req dropped in S_BURST while c_req=1: c_gnt=1 in that same cycle; state returns to ARB.
